arbiter_rr4_ctrl: RTL

//  Round-robin arbiter/scheduler granting one of 4 requesters exclusive use of a shared

---
 rtl/arbiter_rr4_ctrl_if.sv | 13 +
 rtl/arbiter_rr4_ctrl.sv | 109 ++++++++++
 2 files changed

// File: rtl/arbiter_rr4_ctrl_if.sv
// Request/grant bundle between the requesters and the 4-way round-robin arbiter.
// The master side drives requests and release; the slave side is the arbiter.
interface arbiter_rr4_ctrl_if;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_vld;
    logic       timeout;

    modport master (output req, done, input gnt, gnt_idx, gnt_vld, timeout);
    modport slave  (input req, done, output gnt, gnt_idx, gnt_vld, timeout);
endinterface

// File: rtl/arbiter_rr4_ctrl.sv
// Round-robin arbiter for 4 requesters with held grants, owner release,
// request-drop release and an optional hold-time limit that pulses timeout.
module arbiter_rr4_ctrl #(
    parameter int HOLD_MAX = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    arbiter_rr4_ctrl_if.slave        bus
);

    typedef enum logic [0:0] {IDLE = 1'b0, GRANT = 1'b1} state_t;

    state_t     state_q, state_d;
    logic [3:0] gnt_q,   gnt_d;
    logic [1:0] idx_q,   idx_d;
    logic [1:0] ptr_q,   ptr_d;
    logic [7:0] cnt_q,   cnt_d;

    logic [1:0] win_s;
    logic [1:0] cand_s;
    logic       found_s;
    logic       owner_req_s;
    logic       hold_hit_s;
    logic       release_s;

    // Winner search starts just after the last owner, so the last owner ranks lowest.
    always_comb begin
        win_s   = ptr_q;
        cand_s  = ptr_q;
        found_s = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            cand_s = ptr_q + i[1:0];
            if (!found_s && bus.req[cand_s]) begin
                win_s   = cand_s;
                found_s = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

    assign owner_req_s = bus.req[idx_q];
    assign hold_hit_s  = (HOLD_MAX != 0) && (cnt_q == 8'(HOLD_MAX - 1));
    assign release_s   = bus.done || !owner_req_s || hold_hit_s;

    // Next-state and next-grant decisions.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.req != 4'b0000) begin
                    state_d = GRANT;
                    gnt_d   = 4'b0001 << win_s;
                    idx_d   = win_s;
                    ptr_d   = win_s;
                    cnt_d   = 8'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
                if (release_s) begin
                    state_d = IDLE;
                    gnt_d   = 4'b0000;
                    idx_d   = 2'b00;
                end else if (cnt_q != 8'hFF) begin
                    cnt_d = cnt_q + 8'd1;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 4'b0000;
                idx_d   = 2'b00;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // State, grant, pointer and hold counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= 4'b0000;
            idx_q   <= 2'b00;
            ptr_q   <= 2'd3;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Timeout must coincide with the last grant cycle, and a same-cycle done or
    // request drop takes precedence, so it cannot be registered.
    assign bus.timeout = (state_q == GRANT) && hold_hit_s && !bus.done && owner_req_s;
    assign bus.gnt     = gnt_q;
    assign bus.gnt_idx = idx_q;
    assign bus.gnt_vld = |gnt_q;

endmodule
